// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI slave interface slice.
//   state_t       : FSM state encoding shared by the top level and the bench
//   RX/TX_WIDTH   : default word widths (2 command bits + 8 data bits; 8-bit read data)
//   CMD_*         : two-bit command codes carried in rx_data[9:8]
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  localparam int RX_WIDTH_DEF = 10;
  localparam int TX_WIDTH_DEF = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_if_if.sv
// spi_slave_bus -- SPI pins plus the parallel handshake to the memory stage.
//   SS_n, MOSI, MISO     : serial side (SPI clock is the system clk)
//   rx_data, rx_valid    : assembled word and its one-cycle strobe
//   tx_data, tx_valid    : read data returned by the memory stage
//   frame_err            : only present when SPI_SLAVE_FRAME_ERR_EN is defined
// Modports: master (SPI master + memory stage side), slave (this block).
interface spi_slave_bus
  import spi_pkg::*;
#(
  parameter int RX_WIDTH = RX_WIDTH_DEF,
  parameter int TX_WIDTH = TX_WIDTH_DEF
);

  logic                SS_n;
  logic                MOSI;
  logic                MISO;
  logic [RX_WIDTH-1:0] rx_data;
  logic                rx_valid;
  logic [TX_WIDTH-1:0] tx_data;
  logic                tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                frame_err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err
  );
`else
  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
`endif

endinterface

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter -- loads a read word and shifts it out on MISO, MSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture data; MISO shows the MSB the following cycle
//   abort      : drop any shift in progress and force MISO low
//   data       : word to transmit
//   miso       : registered serial output, 0 whenever not shifting
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int TX_WIDTH = TX_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                abort,
  input  logic [TX_WIDTH-1:0] data,
  output logic                miso
);

  localparam int CW = $clog2(TX_WIDTH);

  logic [TX_WIDTH-1:0] shift_q;
  logic [CW-1:0]       remaining;
  logic                miso_q;

  // The MSB goes straight to MISO on load, so the register only holds the
  // bits still to come and 'remaining' counts them down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      remaining <= '0;
      miso_q    <= 1'b0;
    end else if (abort) begin
      shift_q   <= '0;
      remaining <= '0;
      miso_q    <= 1'b0;
    end else if (load) begin
      miso_q    <= data[TX_WIDTH-1];
      shift_q   <= {data[TX_WIDTH-2:0], 1'b0};
      remaining <= CW'(TX_WIDTH-1);
    end else if (remaining != '0) begin
      miso_q    <= shift_q[TX_WIDTH-1];
      shift_q   <= {shift_q[TX_WIDTH-2:0], 1'b0};
      remaining <= remaining - 1'b1;
    end else begin
      miso_q    <= 1'b0;
    end
  end

  assign miso = miso_q;

endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if -- SPI slave front end for a small memory stage.
// Receives a 10-bit frame (2 command bits + 8 data bits) MSB first, strobes it
// to the memory stage, and for read-data frames returns tx_data on MISO.
//   clk   : system clock, also the SPI clock (rising edge)
//   rst_n : asynchronous active-low reset
//   bus   : spi_slave_bus.slave (SS_n, MOSI, MISO, rx_data/rx_valid, tx_data/tx_valid)
// Optional feature: define SPI_SLAVE_FRAME_ERR_EN to add bus.frame_err, a one-cycle
// pulse when SS_n rises after the command bit but before the frame completes.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int RX_WIDTH = RX_WIDTH_DEF,
  parameter int TX_WIDTH = TX_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_slave_bus.slave bus
);

  localparam logic [3:0] LAST_CNT = 4'(RX_WIDTH-2);

  state_t              state, state_next;
  logic [3:0]          bit_cnt;
  logic [RX_WIDTH-1:0] rx_shift;
  logic [RX_WIDTH-1:0] rx_data_q;
  logic                rx_valid_q;
  logic                frame_done;
  logic                rd_addr_seen;
  logic                sample_en;
  logic                last_bit;
  logic                tx_load;
  logic                tx_abort;

  // Next state and sampling control. frame_done freezes a completed frame
  // until SS_n releases, so no extra bits are ever taken.
  always_comb begin
    state_next = state;
    sample_en  = 1'b0;
    last_bit   = 1'b0;
    if (bus.SS_n) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = CHK_CMD;
        CHK_CMD: begin
          sample_en = 1'b1;
          if (bus.MOSI == CMD_WR_ADDR[1])
            state_next = WRITE;
          else if (rd_addr_seen)
            state_next = READ_DATA;
          else
            state_next = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          sample_en = !frame_done;
          last_bit  = !frame_done && (bit_cnt == LAST_CNT);
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Receive path. SS_n high discards any partial word, and because it is
  // checked first it also kills a frame whose last bit arrives with SS_n high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_done   <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (bus.SS_n) begin
        bit_cnt    <= '0;
        rx_shift   <= '0;
        frame_done <= 1'b0;
      end else if (sample_en) begin
        rx_shift <= {rx_shift[RX_WIDTH-2:0], bus.MOSI};
        if (state != CHK_CMD) begin
          if (last_bit) begin
            rx_data_q  <= {rx_shift[RX_WIDTH-2:0], bus.MOSI};
            rx_valid_q <= 1'b1;
            frame_done <= 1'b1;
            bit_cnt    <= '0;
            if (state == READ_ADD)
              rd_addr_seen <= 1'b1;
            else if (state == READ_DATA)
              rd_addr_seen <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q;

  // A frame is only in error once the command bit has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_err_q <= 1'b0;
    else
      frame_err_q <= bus.SS_n && !frame_done &&
                     (state inside {WRITE, READ_ADD, READ_DATA});
  end

  assign bus.frame_err = frame_err_q;
`endif

  // Read data is accepted only once this READ_DATA frame has been strobed.
  assign tx_load  = bus.tx_valid && !bus.SS_n && (state == READ_DATA) && frame_done;
  assign tx_abort = bus.SS_n || (state != READ_DATA);

  spi_tx_shifter #(.TX_WIDTH(TX_WIDTH)) u_tx_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tx_load),
    .abort (tx_abort),
    .data  (bus.tx_data),
    .miso  (bus.MISO)
  );

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if -- self-checking bench for spi_slave_if.
// Inputs change on the falling edge and outputs are compared there too,
// half a cycle clear of the rising edge the DUT uses.
module tb_spi_slave_if;
  import spi_pkg::*;

  typedef struct {
    string      name;
    logic [9:0] word;
    logic [9:0] exp_rx;
    state_t     exp_state;
    logic       exp_seen;
    logic       do_tx;
    logic [7:0] txd;
    logic [7:0] exp_miso;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   rxPulses;
  logic misoSeen;
  vec_t vecs[9];
  vec_t v;

  spi_slave_bus #(.RX_WIDTH(10), .TX_WIDTH(8)) bus ();

  spi_slave_if #(.RX_WIDTH(10), .TX_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every rx_valid strobe so extra pulses are caught per frame.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1)
      rxPulses++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Runs one complete frame, with tx_valid held high during the bits to
  // show it is ignored, then optionally the MISO read-back phase.
  task automatic applyStimulus(input vec_t vec);
    rxPulses = 0;
    misoSeen = 1'b0;
    @(negedge clk);
    bus.SS_n     = 1'b0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      bus.MOSI = vec.word[i];
      misoSeen = misoSeen | bus.MISO;
    end
    @(negedge clk);
    checkOutput({vec.name, "_rx_valid"}, 32'(bus.rx_valid), 32'd1);
    checkOutput({vec.name, "_rx_data"}, 32'(bus.rx_data), 32'(vec.exp_rx));
    checkOutput({vec.name, "_state"}, 32'(dut.state), 32'(vec.exp_state));
    checkOutput({vec.name, "_rd_addr_seen"}, 32'(dut.rd_addr_seen), 32'(vec.exp_seen));
    misoSeen = misoSeen | bus.MISO;
    if (vec.do_tx)
      bus.tx_valid = 1'b0;
    @(negedge clk);
    checkOutput({vec.name, "_rx_strobe_len"}, 32'(bus.rx_valid), 32'd0);
    misoSeen = misoSeen | bus.MISO;
    checkOutput({vec.name, "_miso_quiet"}, 32'(misoSeen), 32'd0);
    if (vec.do_tx) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = vec.txd;
      for (int b = 7; b >= 0; b--) begin
        @(negedge clk);
        bus.tx_valid = 1'b0;
        checkOutput($sformatf("%s_miso_bit%0d", vec.name, b), 32'(bus.MISO), 32'(vec.exp_miso[b]));
      end
      @(negedge clk);
      checkOutput({vec.name, "_miso_done"}, 32'(bus.MISO), 32'd0);
    end else begin
      repeat (2) @(negedge clk);
      checkOutput({vec.name, "_miso_spurious"}, 32'(bus.MISO), 32'd0);
    end
    bus.SS_n     = 1'b1;
    bus.tx_valid = 1'b0;
    @(negedge clk);
    checkOutput({vec.name, "_idle"}, 32'(dut.state), 32'(IDLE));
    #1;
    checkOutput({vec.name, "_pulse_count"}, 32'(rxPulses), 32'd1);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rxPulses     = 0;
    rst_n        = 1'b0;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    vecs[0] = '{"wr_addr",    10'h014, 10'h014, WRITE,     1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{"wr_data",    10'h1A5, 10'h1A5, WRITE,     1'b0, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{"rd_addr",    10'h214, 10'h214, READ_ADD,  1'b1, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{"rd_data",    10'h300, 10'h300, READ_DATA, 1'b0, 1'b1, 8'hA5, 8'b1010_0101};
    vecs[4] = '{"rd_addr2",   10'h2AA, 10'h2AA, READ_ADD,  1'b1, 1'b0, 8'h00, 8'h00};
    vecs[5] = '{"wr_between", 10'h055, 10'h055, WRITE,     1'b1, 1'b0, 8'h00, 8'h00};
    vecs[6] = '{"rd_data2",   10'h381, 10'h381, READ_DATA, 1'b0, 1'b1, 8'h3C, 8'b0011_1100};
    vecs[7] = '{"rd_no_addr", 10'h3FF, 10'h3FF, READ_ADD,  1'b1, 1'b0, 8'h00, 8'h00};
    vecs[8] = '{"after_abort",10'h3C3, 10'h3C3, READ_DATA, 1'b0, 1'b1, 8'h5A, 8'b0101_1010};

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_rx_data", 32'(bus.rx_data), 32'd0);
    checkOutput("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    checkOutput("rst_miso", 32'(bus.MISO), 32'd0);
    checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
    checkOutput("rst_rd_addr_seen", 32'(dut.rd_addr_seen), 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    checkOutput("rst_frame_err", 32'(bus.frame_err), 32'd0);
`endif
    rst_n = 1'b1;

    // Spurious tx_valid while idle
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    repeat (3) @(negedge clk);
    checkOutput("idle_miso_spurious", 32'(bus.MISO), 32'd0);
    bus.tx_valid = 1'b0;

    for (int k = 0; k < 8; k++) begin
      v = vecs[k];
      applyStimulus(v);
    end

    // Abort after 5 bits of a read-data frame; rd_addr_seen is 1 here and must stay 1
    rxPulses = 0;
    @(negedge clk);
    bus.SS_n = 1'b0;
    for (int i = 9; i >= 5; i--) begin
      @(negedge clk);
      bus.MOSI = v.word[i];
    end
    @(negedge clk);
    bus.SS_n = 1'b1;
    @(negedge clk);
    checkOutput("abort5_state", 32'(dut.state), 32'(IDLE));
    checkOutput("abort5_bit_cnt", 32'(dut.bit_cnt), 32'd0);
    checkOutput("abort5_rx_valid", 32'(bus.rx_valid), 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    checkOutput("abort5_frame_err", 32'(bus.frame_err), 32'd1);
`endif
    @(negedge clk);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    checkOutput("abort5_frame_err_len", 32'(bus.frame_err), 32'd0);
`endif
    checkOutput("abort5_pulses", 32'(rxPulses), 32'd0);
    checkOutput("abort5_rd_addr_seen", 32'(dut.rd_addr_seen), 32'd1);

    // SS_n rises exactly as bit 0 is sampled
    rxPulses = 0;
    @(negedge clk);
    bus.SS_n = 1'b0;
    for (int i = 9; i >= 1; i--) begin
      @(negedge clk);
      bus.MOSI = 1'b1;
    end
    @(negedge clk);
    bus.MOSI = 1'b1;
    bus.SS_n = 1'b1;
    @(negedge clk);
    checkOutput("abort0_rx_valid", 32'(bus.rx_valid), 32'd0);
    checkOutput("abort0_state", 32'(dut.state), 32'(IDLE));
    checkOutput("abort0_rx_data_held", 32'(bus.rx_data), 32'h3FF);
    @(negedge clk);
    checkOutput("abort0_pulses", 32'(rxPulses), 32'd0);
    checkOutput("abort0_rd_addr_seen", 32'(dut.rd_addr_seen), 32'd1);

    v = vecs[8];
    applyStimulus(v);

    // Reset during bit 3 of a MISO shift of 0xFF
    v = vecs[2];
    applyStimulus(v);
    @(negedge clk);
    bus.SS_n = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      bus.MOSI = (i >= 8) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    checkOutput("rstmid_rx_data", 32'(bus.rx_data), 32'h300);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rstmid_miso_bit3", 32'(bus.MISO), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_miso", 32'(bus.MISO), 32'd0);
    checkOutput("rstmid_state", 32'(dut.state), 32'(IDLE));
    checkOutput("rstmid_rx_valid", 32'(bus.rx_valid), 32'd0);
    checkOutput("rstmid_rx_data_clr", 32'(bus.rx_data), 32'd0);
    checkOutput("rstmid_shift_clr", 32'(dut.u_tx_shifter.shift_q), 32'd0);
    @(negedge clk);
    bus.SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    v = vecs[0];
    applyStimulus(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
